image_reader: RTL

Layer-0 input fetcher for the ConvNN accelerator. On a start request it takes the image index published by the image manager and reads that image from the shared image memory in row-major order. It streams the pixels to the layer-0 convolution engine over a valid/ready interface, and pulses `frame_done` once the last pixel has been accepted. The manager uses that pulse as the trigger to advance its image index.

---
 rtl/image_pkg.sv | 17 +
 rtl/image_skid_fifo.sv | 51 +++++
 rtl/image_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/image_pkg.sv
// Constants shared by the ConvNN image manager and image_reader, plus the
// image_reader FSM state encoding.
package image_pkg;

  localparam int IMAGE_WIDTH  = 6;
  localparam int IMAGE_HEIGHT = 6;
  localparam int IMAGE_NUM    = 10;
  localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } reader_state_t;

endpackage

// File: rtl/image_skid_fifo.sv
// Two-entry FIFO that holds tagged pixels between image memory and layer 0.
// A push together with a pop is accepted even when the FIFO is full.
module image_skid_fifo #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occupancy,
  output logic             full,
  output logic             empty
);
  import image_pkg::*;

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign occupancy = count;
  assign head      = slot[rd_ptr];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/image_reader.sv
// Layer-0 input fetcher: streams one stored image, row-major, over valid/ready.
// Define IMAGE_READER_ZERO_PAD_EN to add a one-pixel zero border to the frame.
module image_reader #(
  parameter int IMAGE_WIDTH  = image_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = image_pkg::IMAGE_HEIGHT,
  parameter int IMAGE_NUM    = image_pkg::IMAGE_NUM,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3:0]            image_idx,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  row_last,
  output logic                  frame_last,
  output logic                  frame_done,
  output logic                  busy
);
  import image_pkg::*;

`ifdef IMAGE_READER_ZERO_PAD_EN
  localparam int OUT_W   = IMAGE_WIDTH + 2;
  localparam int OUT_H   = IMAGE_HEIGHT + 2;
  localparam int ENTRY_W = DATA_WIDTH + 3;
`else
  localparam int OUT_W   = IMAGE_WIDTH;
  localparam int OUT_H   = IMAGE_HEIGHT;
  localparam int ENTRY_W = DATA_WIDTH + 2;
`endif
  localparam int COL_W = $clog2(OUT_W + 1);
  localparam int ROW_W = $clog2(OUT_H + 1);
  localparam logic [ADDR_WIDTH-1:0] FRAME_WORDS = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT);

  reader_state_t state, state_next;

  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  start;
  logic                  issue;
  logic                  slot_ok;
  logic                  col_last;
  logic                  last_pos;
  logic                  read_slot;
  logic                  infl_valid;
  logic                  infl_row_last;
  logic                  infl_frame_last;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_occ;
  logic [ENTRY_W-1:0]    in_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic [ENTRY_W-1:0]    out_entry;
  logic                  out_pad;
  logic                  xfer;

  assign col_last = (col == COL_W'(OUT_W - 1));
  assign last_pos = col_last && (row == ROW_W'(OUT_H - 1));

  // A slot may be issued only if every beat already owed to the FIFO still fits.
  assign slot_ok = !fifo_full && (({1'b0, fifo_occ} + {2'b0, infl_valid}) < 3'd2);

`ifdef IMAGE_READER_ZERO_PAD_EN
  logic infl_pad;
  logic slot_pad;
  assign slot_pad  = (row == '0) || (row == ROW_W'(OUT_H - 1)) || (col == '0) || col_last;
  assign read_slot = issue && !slot_pad;
  assign in_entry  = {infl_pad, infl_frame_last, infl_row_last, mem_rd_data};
  assign out_pad   = out_entry[DATA_WIDTH+2];
`else
  assign read_slot = issue;
  assign in_entry  = {infl_frame_last, infl_row_last, mem_rd_data};
  assign out_pad   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    issue      = 1'b0;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    case (state)
      IDLE: begin
        if (enable && (32'(image_idx) < IMAGE_NUM)) begin
          start      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (slot_ok) begin
          issue = 1'b1;
          if (last_pos) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer && frame_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Scan counters, running read address, and the one-deep read-latency stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row             <= '0;
      col             <= '0;
      addr            <= '0;
      infl_valid      <= 1'b0;
      infl_row_last   <= 1'b0;
      infl_frame_last <= 1'b0;
`ifdef IMAGE_READER_ZERO_PAD_EN
      infl_pad        <= 1'b0;
`endif
    end else begin
      infl_valid      <= issue;
      infl_row_last   <= issue && col_last;
      infl_frame_last <= issue && last_pos;
`ifdef IMAGE_READER_ZERO_PAD_EN
      infl_pad        <= issue && slot_pad;
`endif
      if (start) begin
        row  <= '0;
        col  <= '0;
        addr <= ADDR_WIDTH'(image_idx) * FRAME_WORDS;
      end else if (issue) begin
        if (col_last) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        if (read_slot) begin
          addr <= addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign mem_rd_en = read_slot;
  assign mem_addr  = addr;

  // Returning read data bypasses the FIFO when it is empty and layer 0 is ready.
  assign out_entry  = fifo_empty ? in_entry : head_entry;
  assign data_valid = infl_valid || !fifo_empty;
  assign xfer       = data_valid && data_ready;
  assign fifo_push  = infl_valid && !(fifo_empty && data_ready);
  assign fifo_pop   = xfer && !fifo_empty;
  assign data_out   = (data_valid && !out_pad) ? out_entry[DATA_WIDTH-1:0] : '0;
  assign row_last   = data_valid && out_entry[DATA_WIDTH];
  assign frame_last = data_valid && out_entry[DATA_WIDTH+1];

  image_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (in_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .occupancy (fifo_occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
